// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath width, register-file geometry and the
// architecturally named registers.
// No ports; imported by reg_file and rf_read_port.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: forces address 0 to zero and,
// when BYPASS_EN=1, forwards the in-flight write data on an address match.
// Ports: rd_addr/reg_val in (address and stored value), byp_vld/wr_addr/wr_data in (write under way), rd_data out.
module rf_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int ADDR_W    = mips_pkg::REG_ADDR_W,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              byp_vld,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = reg_val;
    // byp_vld already excludes address 0 and reset, so only the address match remains.
    if (BYPASS_EN && byp_vld && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
    // The zero check comes last so $0 reads 0 even if a bypass matched.
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two ALU read ports (rs, rt), one
// writeback port and an independent debug read port; $0 is hardwired to zero.
// Ports: clk, rst (async, active-high clear); rs_addr/rs_data, rt_addr/rt_data;
//        we/wr_addr/wr_data (write at rising edge); dbg_addr/dbg_data.
// Macro REG_FILE_BYPASS_EN: when defined, rs/rt forward wr_data on a same-cycle
// address match (write-first); otherwise reads return the pre-edge value. dbg never bypasses.
// NUM_REGS must equal 2**ADDR_W.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

`ifdef REG_FILE_BYPASS_EN
  localparam bit ALU_BYPASS = 1'b1;
`else
  localparam bit ALU_BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_vld;

  // A write is live only outside reset and never to $0; the same qualifier gates
  // the bypass so reads stay 0 while rst is high.
  assign wr_vld = we && !rst && (wr_addr != ADDR_W'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (wr_vld) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Plain flops rather than a RAM: reset has to clear every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(ALU_BYPASS)) u_rs_port (
    .rd_addr (rs_addr),
    .reg_val (regs_q[rs_addr]),
    .byp_vld (wr_vld),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rs_data)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(ALU_BYPASS)) u_rt_port (
    .rd_addr (rt_addr),
    .reg_val (regs_q[rt_addr]),
    .byp_vld (wr_vld),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rt_data)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(1'b0)) u_dbg_port (
    .rd_addr (dbg_addr),
    .reg_val (regs_q[dbg_addr]),
    .byp_vld (wr_vld),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (dbg_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic
// compared against an array model of the architectural register contents.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data, wr_data;
  logic        we;

  logic [31:0] mdl [32];
  int          total;
  int          bad;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Expected read value from architectural rules: $0 is zero, optional
  // forwarding of a live write, otherwise the stored value.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we && (wr_addr == a)) return wr_data;
    return mdl[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  // One cycle: drive after the falling edge, check reads before the rising
  // edge, then commit the write into the model.
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                      input string tag);
    @(negedge clk);
    we = w; wr_addr = wa; wr_data = wd;
    rs_addr = ra; rt_addr = rb; dbg_addr = rd;
    #1;
    check({tag, ".rs"},  rs_data,  exp_rd(ra, BYP));
    check({tag, ".rt"},  rt_data,  exp_rd(rb, BYP));
    check({tag, ".dbg"}, dbg_data, exp_rd(rd, 1'b0));
    @(posedge clk);
    if (w && wa != 5'd0) mdl[wa] = wd;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_model();
    rst = 1'b1; we = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFEF00D;
    rs_addr = 5'd1; rt_addr = 5'd31; dbg_addr = 5'd17;

    // Reset: reads are zero, and the write held during reset is dropped.
    #12;
    check("rst.rs",  rs_data,  32'h0);
    check("rst.rt",  rt_data,  32'h0);
    check("rst.dbg", dbg_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    #1;
    dbg_addr = 5'd4;
    #1;
    check("rst.drop", dbg_data, 32'h0);

    // Read after reset.
    step(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd17, "t1");

    // Write then read back on both ALU ports.
    step(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8, 5'd8, "t2w");
    step(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8, "t2r");
    check("t2.const", rs_data, 32'hDEADBEEF);

    // $0 cannot be written.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, "t3w");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "t3r");
    check("t3.const", rs_data, 32'h0);

    // Collision: old value unless bypass is built in; dbg always old.
    step(1'b1, 5'd5, 32'h11111111, 5'd0, 5'd0, 5'd0, "t4a");
    step(1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5, 5'd5, "t4b");
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5, "t4c");
    check("t4.after", dbg_data, 32'h22222222);

    // Asynchronous reset between edges, with a write presented during it.
    step(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0, "t5w");
    @(negedge clk);
    we = 1'b0; rs_addr = 5'd3; rt_addr = 5'd3; dbg_addr = 5'd3;
    #1;
    check("t5.pre", rs_data, 32'hA5A5A5A5);
    #1;
    rst = 1'b1;
    #1;
    clear_model();
    check("t5.async", rs_data, 32'h0);
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    #1;
    check("t5.rtbyp", rt_data, 32'h0);
    @(posedge clk);
    #1;
    check("t5.held", dbg_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    #1;
    check("t5.nowr", dbg_data, 32'h0);

    // Sweep every register through the debug port.
    for (int i = 1; i < 32; i++) begin
      step(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0, 5'd0, "t6w");
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i), "t6r");
      check("t6.sweep", dbg_data, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
    end

    // Random traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  wa, ra, rb, rd;
      logic        w;
      logic [31:0] wd;
      w  = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(w, wa, wd, ra, rb, rd, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
